// File: rtl/multicycle_control_if.sv
// Control <-> datapath bundle for the multicycle MIPS controller.
// master = controller (drives strobes/selects), slave = datapath (drives decode fields and flags).
interface multicycle_control_if #(parameter int CNT_W = 32);
  logic [5:0]       Op;
  logic [5:0]       Funct;
  logic             Zero;
  logic             MemReady;
  logic             IorD;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [5:0]       ALUControl;
  logic [1:0]       PCSrc;
  logic             PCEn;
  logic             Illegal;
  logic [3:0]       State;
  logic [CNT_W-1:0] Retired;

  modport master (
    input  Op, Funct, Zero, MemReady,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
           ALUControl, PCSrc, PCEn, Illegal, State, Retired
  );

  modport slave (
    output Op, Funct, Zero, MemReady,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
           ALUControl, PCSrc, PCEn, Illegal, State, Retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on MemReady and counts retired instructions.
module multicycle_control #(
  parameter logic [5:0] ALU_ADD = 6'h20,
  parameter logic [5:0] ALU_SUB = 6'h22,
  parameter int         CNT_W   = 32
) (
  input logic                  CLK,
  input logic                  RESET,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD  = 4'd3,
    MEMWB = 4'd4, MEMWR  = 4'd5, EXEC   = 4'd6, ALUWB  = 4'd7,
    BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                         OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;

  state_t           state, nxt;
  logic [CNT_W-1:0] retired;
  logic             pcwrite, branch, mwr, irw, rw, illg, retire;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= FETCH;
      retired <= '0;
    end else begin
      state <= nxt;
      if (retire) retired <= retired + 1'b1;
    end
  end

  always_comb begin
    nxt            = FETCH;
    bus.IorD       = 1'b0;
    mwr            = 1'b0;
    irw            = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    rw             = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = ALU_ADD;
    bus.PCSrc      = 2'b00;
    pcwrite        = 1'b0;
    branch         = 1'b0;
    illg           = 1'b0;
    retire         = 1'b0;
    case (state)
      FETCH: begin
        bus.ALUSrcB = 2'b01;
        irw         = bus.MemReady;
        pcwrite     = bus.MemReady;
        nxt         = bus.MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.Op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXEC;
          OP_BEQ:       nxt = BRANCH;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JUMP;
          default: begin
            nxt  = FETCH;
            illg = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        nxt         = (bus.Op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.IorD = 1'b1;
        nxt      = bus.MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.MemtoReg = 1'b1;
        rw           = 1'b1;
        retire       = 1'b1;
      end
      MEMWR: begin
        bus.IorD = 1'b1;
        mwr      = 1'b1;
        nxt      = bus.MemReady ? FETCH : MEMWR;
        retire   = bus.MemReady;
      end
      EXEC: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUControl = bus.Funct;
        nxt            = ALUWB;
      end
      ALUWB: begin
        bus.RegDst = 1'b1;
        rw         = 1'b1;
        retire     = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUControl = ALU_SUB;
        bus.PCSrc      = 2'b01;
        branch         = 1'b1;
        retire         = 1'b1;
      end
      ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        nxt         = ADDIWB;
      end
      ADDIWB: begin
        rw     = 1'b1;
        retire = 1'b1;
      end
      JUMP: begin
        bus.PCSrc = 2'b10;
        pcwrite   = 1'b1;
        retire    = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  // state-changing strobes are suppressed while reset is held
  assign bus.MemWrite = mwr & ~RESET;
  assign bus.IRWrite  = irw & ~RESET;
  assign bus.RegWrite = rw & ~RESET;
  assign bus.PCEn     = (pcwrite | (branch & bus.Zero)) & ~RESET;
  assign bus.Illegal  = illg & ~RESET;
  assign bus.State    = state;
  assign bus.Retired  = retired;
endmodule
